// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types, default address map and alignment helper for the
// MEM-stage load/store interconnect (pipeline_mem_bus).
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int N_SLV_DEF = 4;

  // Slave i lives at [i*32 +: 32]. UART entries sit below PERIPH so they win
  // where their windows overlap the PERIPH window.
  //   0 DMEM 1 UART 2 UART_CON 3 PERIPH
  localparam logic [N_SLV_DEF*32-1:0] SLV_BASE_DEF = {
    32'h4000_0000,  // PERIPH
    32'h4000_0020,  // UART_CON
    32'h4000_0018,  // UART
    32'h0000_0000   // DMEM
  };

  localparam logic [N_SLV_DEF*32-1:0] SLV_MASK_DEF = {
    32'hFFFF_FFC0,  // PERIPH
    32'hFFFF_FFFC,  // UART_CON
    32'hFFFF_FFF8,  // UART
    32'hC000_0000   // DMEM
  };

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic align_ok(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_H:    return !lo[0];
      SZ_W:    return (lo == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_mem_bus_if.sv
// pipeline_mem_bus_if: request/ack slave bus between the MEM-stage
// interconnect (master) and the N_SLV slave channels.
//
// Handshake: the master holds s_req (one-hot), s_we, s_addr, s_be and s_wdata
// stable from the first cycle s_req is high until the cycle the addressed
// slave raises its s_ack bit. s_ack may arrive in the same cycle as s_req.
// Read data on s_rdata is only consumed in the ack cycle.
interface pipeline_mem_bus_if #(
  parameter int N_SLV  = 4,
  parameter int DATA_W = 32
);
  logic [N_SLV-1:0]        s_req;
  logic                    s_we;
  logic [31:0]             s_addr;
  logic [DATA_W/8-1:0]     s_be;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ack;

  modport master (
    output s_req, s_we, s_addr, s_be, s_wdata,
    input  s_rdata, s_ack
  );

  modport slave (
    input  s_req, s_we, s_addr, s_be, s_wdata,
    output s_rdata, s_ack
  );
endinterface

// File: rtl/mem_bus_lane_align.sv
// mem_bus_lane_align: store-data lane replication, byte-enable generation and
// load-data lane extraction with zero/sign extension (32-bit data path).
module mem_bus_lane_align
  import mem_bus_pkg::*;
(
  input  size_e       size,
  input  logic        sext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_rep,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane steering for stores and loads, selected by access size.
  always_comb begin
    be      = 4'b1111;
    st_rep  = st_data;
    ld_byte = ld_word[8*addr_lo +: 8];
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (size)
      SZ_B: begin
        be      = 4'b0001 << addr_lo;
        st_rep  = {4{st_data[7:0]}};
        ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_rep  = {2{st_data[15:0]}};
        ld_data = {{16{sext & ld_half[15]}}, ld_half};
      end
      default: begin
        be      = 4'b1111;
        st_rep  = st_data;
        ld_data = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_mem_bus.sv
// pipeline_mem_bus: MEM-stage load/store interconnect. Decodes mem_addr into
// N_SLV regions, drives a request/ack slave bus, stalls the pipeline while a
// slave is slow, and flags unmapped/misaligned accesses on bus_err.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (abort a WAIT after TIMEOUT cycles).
module pipeline_mem_bus
  import mem_bus_pkg::*;
#(
  parameter int                  DATA_W   = 32,
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = SLV_BASE_DEF,
  parameter logic [N_SLV*32-1:0] SLV_MASK = SLV_MASK_DEF,
  parameter int                  TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          mem_size,
  input  logic                mem_sext,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_busb,
  input  logic                fwd_sw,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [31:0]         mem_outa,
  output logic [DATA_W-1:0]   mem_outb,
  output logic                mem_stall,
  output logic                bus_err,
  pipeline_mem_bus_if.master  bus,
  output state_e              dbg_state
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [N_SLV-1:0]    req_q, req_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  size_e               size_q, size_d;
  logic                sext_q, sext_d;

`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
`else
  logic [7:0]          unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  size_e               sz_live;
  logic                hit;
  logic [N_SLV-1:0]    sel_oh;
  logic [N_SLV-1:0]    act_req;
  logic [DATA_W-1:0]   rd_word;
  logic                ack_hit;
  logic [DATA_W-1:0]   st_data;
  size_e               la_size;
  logic                la_sext;
  logic [1:0]          la_lo;
  logic [BE_W-1:0]     la_be;
  logic [DATA_W-1:0]   la_wdata;
  logic [DATA_W-1:0]   la_rdata;

  logic [N_SLV-1:0]    req_c;
  logic                we_c;
  logic [31:0]         addr_c;
  logic [BE_W-1:0]     be_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                stall_c;
  logic                err_c;
  logic [DATA_W-1:0]   outb_c;

  assign sz_live  = (mem_size == 2'b11) ? SZ_W : size_e'(mem_size);
  assign st_data  = fwd_sw ? wb_data : mem_busb;
  assign act_req  = (state_q == ST_WAIT) ? req_q : sel_oh;
  assign la_size  = (state_q == ST_WAIT) ? size_q : sz_live;
  assign la_sext  = (state_q == ST_WAIT) ? sext_q : mem_sext;
  assign la_lo    = (state_q == ST_WAIT) ? addr_q[1:0] : mem_addr[1:0];

  // Region decode: scanning downwards leaves the lowest matching index selected.
  always_comb begin
    hit    = 1'b0;
    sel_oh = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        hit       = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Read-data mux and ack detection for the active (live or held) request.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (act_req[i]) rd_word = bus.s_rdata[i*DATA_W +: DATA_W];
    end
    ack_hit = |(act_req & bus.s_ack);
  end

  mem_bus_lane_align u_lane_align (
    .size    (la_size),
    .sext    (la_sext),
    .addr_lo (la_lo),
    .st_data (st_data),
    .ld_word (rd_word),
    .be      (la_be),
    .st_rep  (la_wdata),
    .ld_data (la_rdata)
  );

  // Next-state and bus/pipeline outputs for the IDLE/WAIT access FSM.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    req_c   = '0;
    we_c    = 1'b0;
    addr_c  = {mem_addr[31:2], 2'b00};
    be_c    = '0;
    wdata_c = '0;
    stall_c = 1'b0;
    err_c   = 1'b0;
    outb_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (mem_rd || mem_wr) begin
          if (!hit || !align_ok(sz_live, mem_addr[1:0])) begin
            err_c = 1'b1;
          end else begin
            req_c   = sel_oh;
            we_c    = mem_wr;
            be_c    = la_be;
            wdata_c = la_wdata;
            if (ack_hit) begin
              // A write wins over a simultaneous read, so only pure loads return data.
              if (!mem_wr) outb_c = la_rdata;
            end else begin
              stall_c = 1'b1;
              state_d = ST_WAIT;
              req_d   = sel_oh;
              we_d    = mem_wr;
              addr_d  = mem_addr;
              be_d    = la_be;
              wdata_d = la_wdata;
              size_d  = sz_live;
              sext_d  = mem_sext;
`ifdef MEM_BUS_TIMEOUT_EN
              cnt_d   = 8'd1;
`endif
            end
          end
        end
      end
      ST_WAIT: begin
        req_c   = req_q;
        we_c    = we_q;
        addr_c  = {addr_q[31:2], 2'b00};
        be_c    = be_q;
        wdata_c = wdata_q;
        if (ack_hit) begin
          if (!we_q) outb_c = la_rdata;
          state_d = ST_IDLE;
          req_d   = '0;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
`ifdef MEM_BUS_TIMEOUT_EN
          if (cnt_q == 8'(TIMEOUT)) begin
            err_c   = 1'b1;
            state_d = ST_IDLE;
            req_d   = '0;
            cnt_d   = 8'd0;
          end else begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
`else
          stall_c = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset drops any request, including one held in WAIT, without an error.
    if (!reset) begin
      req_c   = '0;
      stall_c = 1'b0;
      err_c   = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // State and held-request registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_W;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  // Wait-cycle counter used to abort slaves that never acknowledge.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.s_req   = req_c;
  assign bus.s_we    = we_c;
  assign bus.s_addr  = addr_c;
  assign bus.s_be    = be_c;
  assign bus.s_wdata = wdata_c;
  assign mem_outa    = mem_addr;
  assign mem_outb    = outb_c;
  assign mem_stall   = stall_c;
  assign bus_err     = err_c;
  assign dbg_state   = state_q;

endmodule
